// File: rtl/sim_end_monitor.sv
// End-of-test monitor: watches the retire stream for pass/fail addresses, a cycle timeout
// and (with SIM_MON_HANG_EN defined) a no-retire hang; results are held until re-armed.
module sim_end_monitor_match #(
    parameter int XLEN = 32
) (
    input  logic            inst_v,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] addr,
    output logic            hit
);
    assign hit = inst_v & en & (pc == addr);
endmodule

module sim_end_monitor #(
    parameter int XLEN       = 32,
    parameter int NUM_WATCH  = 4,
    parameter int CNT_W      = 32,
    parameter int HANG_LIMIT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      inst_v,
    input  logic [XLEN-1:0]           pc,
    input  logic [NUM_WATCH*XLEN-1:0] watch_addr,
    input  logic [NUM_WATCH-1:0]      watch_en,
    input  logic [NUM_WATCH-1:0]      watch_fail,
    input  logic [CNT_W-1:0]          timeout,
    output logic                      running,
    output logic                      done,
    output logic [2:0]                status,
    output logic [2:0]                hit_idx,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [CNT_W-1:0]          retire_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_PASS = 3'd1;
    localparam logic [2:0] ST_FAIL = 3'd2;
    localparam logic [2:0] ST_TOUT = 3'd3;
    localparam logic [2:0] ST_HANG = 3'd4;

    state_t               state;
    logic [NUM_WATCH-1:0] hit;
    logic                 any_hit, hit_is_fail, hang_hit, tout_hit;
    logic [2:0]           hit_sel;
    logic [CNT_W-1:0]     cycle_inc, retire_inc;

    genvar g;
    generate
        for (g = 0; g < NUM_WATCH; g++) begin : g_ch
            sim_end_monitor_match #(.XLEN(XLEN)) u_match (
                .inst_v (inst_v),
                .en     (watch_en[g]),
                .pc     (pc),
                .addr   (watch_addr[g*XLEN +: XLEN]),
                .hit    (hit[g])
            );
        end
    endgenerate

    // Scan high to low so the lowest matching channel is the one left standing.
    always_comb begin
        any_hit     = 1'b0;
        hit_sel     = 3'd0;
        hit_is_fail = 1'b0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit     = 1'b1;
                hit_sel     = 3'(i);
                hit_is_fail = watch_fail[i];
            end
        end
    end

    assign tout_hit   = (timeout != '0) && (cycle_cnt == timeout - CNT_W'(1));
    assign cycle_inc  = (&cycle_cnt)  ? cycle_cnt  : cycle_cnt  + CNT_W'(1);
    assign retire_inc = (&retire_cnt) ? retire_cnt : retire_cnt + CNT_W'(1);

`ifdef SIM_MON_HANG_EN
    localparam int SW = $clog2(HANG_LIMIT + 1);
    logic [SW-1:0] stall_cnt;

    assign hang_hit = !inst_v && (stall_cnt == SW'(HANG_LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (arm)
            stall_cnt <= '0;
        else if (state == RUN)
            stall_cnt <= inst_v ? '0 : stall_cnt + SW'(1);
    end
`else
    // Stall detection compiled out; this is constant 0.
    assign hang_hit = (HANG_LIMIT < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            running    <= 1'b0;
            done       <= 1'b0;
            status     <= ST_NONE;
            hit_idx    <= 3'd0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else if (arm) begin
            state      <= RUN;
            running    <= 1'b1;
            done       <= 1'b0;
            status     <= ST_NONE;
            hit_idx    <= 3'd0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_inc;
            if (inst_v)
                retire_cnt <= retire_inc;
            if (any_hit || hang_hit || tout_hit) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
            end
            if (any_hit) begin
                status  <= hit_is_fail ? ST_FAIL : ST_PASS;
                hit_idx <= hit_sel;
            end else if (hang_hit) begin
                status  <= ST_HANG;
            end else if (tout_hit) begin
                status  <= ST_TOUT;
            end
        end
    end
endmodule

// File: tb/tb_sim_end_monitor.sv
// Directed bench for sim_end_monitor: cycle table for match/arm behaviour plus
// hand sequences for pass run, re-arm, async reset, timeout and hang.
module tb_sim_end_monitor;
    localparam int XLEN = 32, NW = 4, CW = 32;

    logic             clk = 1'b0, reset = 1'b0, arm = 1'b0, inst_v = 1'b0;
    logic [XLEN-1:0]  pc = '0;
    logic [NW*XLEN-1:0] watch_addr = '0;
    logic [NW-1:0]    watch_en = '0, watch_fail = '0;
    logic [CW-1:0]    timeout = '0;
    logic             running, done;
    logic [2:0]       status, hit_idx;
    logic [CW-1:0]    cycle_cnt, retire_cnt;

    int checks = 0, failures = 0;

    sim_end_monitor #(.XLEN(XLEN), .NUM_WATCH(NW), .CNT_W(CW), .HANG_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .arm(arm), .inst_v(inst_v), .pc(pc),
        .watch_addr(watch_addr), .watch_en(watch_en), .watch_fail(watch_fail),
        .timeout(timeout), .running(running), .done(done), .status(status),
        .hit_idx(hit_idx), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic        v;
        logic [31:0] pc;
        logic        run;
        logic        dn;
        logic [2:0]  st;
        logic [2:0]  hi;
        logic [31:0] cyc;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        repeat (3) step();
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_hit_idx", 32'(hit_idx), 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_retire", retire_cnt, 0);
        reset = 1'b1;
        step();

        // ch0 disabled, ch1 fail / ch2 pass duplicate, ch3 pass
        watch_addr = {32'h80000060, 32'h80000050, 32'h80000050, 32'h80000040};
        watch_en   = 4'b1110;
        watch_fail = 4'b0010;
        timeout    = '0;
        //               arm  v    pc            run  dn   st    hi    cyc ret
        tbl[0]  = '{1'b0, 1'b1, 32'h80000050, 1'b0, 1'b0, 3'd0, 3'd0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 32'h80000050, 1'b1, 1'b0, 3'd0, 3'd0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 32'h80000040, 1'b1, 1'b0, 3'd0, 3'd0, 1, 1};
        tbl[3]  = '{1'b0, 1'b0, 32'h80000044, 1'b1, 1'b0, 3'd0, 3'd0, 2, 1};
        tbl[4]  = '{1'b0, 1'b1, 32'h80000044, 1'b1, 1'b0, 3'd0, 3'd0, 3, 2};
        tbl[5]  = '{1'b0, 1'b0, 32'h80000050, 1'b1, 1'b0, 3'd0, 3'd0, 4, 2};
        tbl[6]  = '{1'b0, 1'b1, 32'h80000050, 1'b0, 1'b1, 3'd2, 3'd1, 5, 3};
        tbl[7]  = '{1'b0, 1'b1, 32'h80000060, 1'b0, 1'b1, 3'd2, 3'd1, 5, 3};
        tbl[8]  = '{1'b1, 1'b1, 32'h80000060, 1'b1, 1'b0, 3'd0, 3'd0, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 32'h80000060, 1'b0, 1'b1, 3'd1, 3'd3, 1, 1};
        tbl[10] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 3'd0, 3'd0, 0, 0};
        tbl[11] = '{1'b1, 1'b1, 32'h80000050, 1'b1, 1'b0, 3'd0, 3'd0, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 32'h80000044, 1'b1, 1'b0, 3'd0, 3'd0, 1, 1};
        tbl[13] = '{1'b0, 1'b1, 32'h80000060, 1'b0, 1'b1, 3'd1, 3'd3, 2, 2};
        for (int i = 0; i < 14; i++) begin
            arm = tbl[i].arm; inst_v = tbl[i].v; pc = tbl[i].pc;
            step();
            chk($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].run));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("tbl%0d_status", i), 32'(status), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_hit_idx", i), 32'(hit_idx), 32'(tbl[i].hi));
            chk($sformatf("tbl%0d_cycle", i), cycle_cnt, tbl[i].cyc);
            chk($sformatf("tbl%0d_retire", i), retire_cnt, tbl[i].ret);
        end

        // Pass hit after 17 sequential retires
        watch_addr = {32'h0, 32'h0, 32'h80000050, 32'h80000040};
        watch_en   = 4'b0011;
        watch_fail = 4'b0010;
        arm = 1'b1; inst_v = 1'b0;
        step();
        chk("pass_arm_running", 32'(running), 1);
        arm = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            inst_v = 1'b1; pc = 32'h80000000 + 32'(4 * k);
            step();
            if (k == 15) chk("pass_not_yet_done", 32'(done), 0);
        end
        inst_v = 1'b0;
        chk("pass_done", 32'(done), 1);
        chk("pass_status", 32'(status), 1);
        chk("pass_hit_idx", 32'(hit_idx), 0);
        chk("pass_retire", retire_cnt, 17);
        chk("pass_running", 32'(running), 0);

        // Re-arm clears results
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("rearm_status", 32'(status), 0);
        chk("rearm_cycle", cycle_cnt, 0);
        chk("rearm_running", 32'(running), 1);
        chk("rearm_done", 32'(done), 0);

        // Asynchronous reset mid-run
        inst_v = 1'b1; pc = 32'h80000100;
        repeat (3) step();
        chk("mid_cycle", cycle_cnt, 3);
        #2 reset = 1'b0;
        #1;
        chk("arst_running", 32'(running), 0);
        chk("arst_cycle", cycle_cnt, 0);
        chk("arst_retire", retire_cnt, 0);
        chk("arst_flags", 32'({done, status, hit_idx}), 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_idle", 32'(running), 0);

        // Timeout at 100 with continuous non-matching retires
        watch_en = '0;
        timeout = 100;
        arm = 1'b1; inst_v = 1'b1; pc = 32'h80000100;
        step();
        arm = 1'b0;
        n = 0;
        while (!done && n < 200) begin step(); n++; end
        chk("tout_edges", 32'(n), 100);
        chk("tout_status", 32'(status), 3);
        chk("tout_cycle", cycle_cnt, 100);
        chk("tout_retire", retire_cnt, 100);

        // Timeout disabled
        timeout = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        seen = 1'b0;
        repeat (10000) begin step(); if (done) seen = 1'b1; end
        chk("notout_done", 32'(seen), 0);
        chk("notout_cycle", cycle_cnt, 10000);
        chk("notout_running", 32'(running), 1);

`ifdef SIM_MON_HANG_EN
        arm = 1'b1; inst_v = 1'b0;
        step();
        arm = 1'b0;
        repeat (9) step();
        inst_v = 1'b1;
        step();
        inst_v = 1'b0;
        chk("hang_restart_not_done", 32'(done), 0);
        n = 0;
        while (!done && n < 100) begin step(); n++; end
        chk("hang_edges", 32'(n), 16);
        chk("hang_status", 32'(status), 4);
`else
        arm = 1'b1; inst_v = 1'b0;
        step();
        arm = 1'b0;
        seen = 1'b0;
        repeat (40) begin step(); if (done || status == 3'd4) seen = 1'b1; end
        chk("nohang_done", 32'(seen), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
